// File: rtl/board_io_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | board_io_pkg: shared LED mode encodings and a width helper for   |
// | the board I/O front end.                                         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package board_io_pkg;

    localparam logic [1:0] LED_MODE_DIRECT = 2'd0;
    localparam logic [1:0] LED_MODE_BLINK  = 2'd1;
    localparam logic [1:0] LED_MODE_PWM    = 2'd2;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_debounce_bit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | io_debounce_bit: synchroniser, tick-based debouncer and          |
// | registered rise/fall pulses for one board input.                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module io_debounce_bit
    import board_io_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_TICKS = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int                 c_CNT_W    = clog2(STABLE_TICKS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            // Any return to the accepted level restarts the stability run.
            if (w_sync == r_level) begin
                r_cnt <= '0;
            end else if (i_tick && (r_cnt == c_CNT_LAST)) begin
                r_level <= w_sync;
                r_cnt   <= '0;
                r_rise  <= w_sync;
                r_fall  <= ~w_sync;
            end else if (i_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/board_io_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | board_io_ctrl: debounced switch/button inputs with edge pulses   |
// | and a software LED register driven direct, blinking or dimmed.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int NUM_SW       = 16,
    parameter int NUM_PB       = 5,
    parameter int NUM_LED      = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 5,
    parameter int BLINK_TICKS  = 250,
    parameter int PWM_BITS     = 8
) (
    input  logic                SI_ClkIn,
    input  logic                SI_Reset_N,
    input  logic [NUM_SW-1:0]   sw_raw,
    input  logic [NUM_PB-1:0]   pb_raw,
    output logic [NUM_SW-1:0]   sw_db,
    output logic [NUM_PB-1:0]   pb_db,
    output logic [NUM_PB-1:0]   pb_rise,
    output logic [NUM_PB-1:0]   pb_fall,
    output logic                sw_change,
    input  logic [NUM_LED-1:0]  led_wdata,
    input  logic                led_we,
    input  logic [1:0]          led_mode,
    input  logic [PWM_BITS-1:0] led_duty,
    output logic [NUM_LED-1:0]  LED
);

    localparam int                   c_PRESC_W    = clog2(TICK_DIV);
    localparam int                   c_BLINK_W    = clog2(BLINK_TICKS);
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_TICKS - 1);

    logic [c_PRESC_W-1:0] r_presc;
    logic                 w_tick;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_phase;
    logic [PWM_BITS-1:0]  r_pwm_cnt;
    logic                 w_pwm_on;
    logic [NUM_LED-1:0]   r_led_reg;
    logic [NUM_LED-1:0]   r_led_out;
    logic [NUM_LED-1:0]   w_led_next;
    logic [NUM_SW-1:0]    w_sw_rise;
    logic [NUM_SW-1:0]    w_sw_fall;

    // One prescaler paces every debouncer and the blink timer.
    assign w_tick = (r_presc == c_PRESC_LAST);

    always_ff @(posedge SI_ClkIn) begin
        if (!SI_Reset_N) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    genvar gi;
    for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
        io_debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS)
        ) u_db (
            .clk     (SI_ClkIn),
            .rst_n   (SI_Reset_N),
            .i_tick  (w_tick),
            .i_raw   (sw_raw[gi]),
            .o_level (sw_db[gi]),
            .o_rise  (w_sw_rise[gi]),
            .o_fall  (w_sw_fall[gi])
        );
    end

    for (gi = 0; gi < NUM_PB; gi++) begin : g_pb
        io_debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS)
        ) u_db (
            .clk     (SI_ClkIn),
            .rst_n   (SI_Reset_N),
            .i_tick  (w_tick),
            .i_raw   (pb_raw[gi]),
            .o_level (pb_db[gi]),
            .o_rise  (pb_rise[gi]),
            .o_fall  (pb_fall[gi])
        );
    end

    assign sw_change = |(w_sw_rise | w_sw_fall);

    // Blink timer runs in every mode so switching into blink is glitch-free.
    always_ff @(posedge SI_ClkIn) begin
        if (!SI_Reset_N) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_tick) begin
            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge SI_ClkIn) begin
        if (!SI_Reset_N) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    assign w_pwm_on = (r_pwm_cnt < led_duty);

    always_ff @(posedge SI_ClkIn) begin
        if (!SI_Reset_N) begin
            r_led_reg <= '0;
        end else if (led_we) begin
            r_led_reg <= led_wdata;
        end
    end

    always_comb begin
        w_led_next = r_led_reg;
        case (led_mode)
            LED_MODE_BLINK: w_led_next = r_led_reg & {NUM_LED{r_phase}};
            LED_MODE_PWM:   w_led_next = r_led_reg & {NUM_LED{w_pwm_on}};
            default:        w_led_next = r_led_reg;
        endcase
    end

    always_ff @(posedge SI_ClkIn) begin
        if (!SI_Reset_N) begin
            r_led_out <= '0;
        end else begin
            r_led_out <= w_led_next;
        end
    end

    assign LED = r_led_out;

endmodule
`default_nettype wire

// File: tb/tb_board_io_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_board_io_ctrl: directed and random stimulus against a         |
// | behavioural model of board_io_ctrl.                              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_board_io_ctrl;

    localparam int NUM_SW       = 16;
    localparam int NUM_PB       = 5;
    localparam int NUM_LED      = 16;
    localparam int SYNC_STAGES  = 2;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;
    localparam int BLINK_TICKS  = 2;
    localparam int PWM_BITS     = 4;
    localparam int NUM_IN       = NUM_SW + NUM_PB;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NUM_SW-1:0]   sw_raw = '0;
    logic [NUM_PB-1:0]   pb_raw = '0;
    logic [NUM_SW-1:0]   sw_db;
    logic [NUM_PB-1:0]   pb_db;
    logic [NUM_PB-1:0]   pb_rise;
    logic [NUM_PB-1:0]   pb_fall;
    logic                sw_change;
    logic [NUM_LED-1:0]  led_wdata = '0;
    logic                led_we = 1'b0;
    logic [1:0]          led_mode = 2'd0;
    logic [PWM_BITS-1:0] led_duty = '0;
    logic [NUM_LED-1:0]  LED;

    int checks   = 0;
    int failures = 0;

    board_io_ctrl #(
        .NUM_SW       (NUM_SW),
        .NUM_PB       (NUM_PB),
        .NUM_LED      (NUM_LED),
        .SYNC_STAGES  (SYNC_STAGES),
        .TICK_DIV     (TICK_DIV),
        .STABLE_TICKS (STABLE_TICKS),
        .BLINK_TICKS  (BLINK_TICKS),
        .PWM_BITS     (PWM_BITS)
    ) dut (
        .SI_ClkIn   (clk),
        .SI_Reset_N (rst_n),
        .sw_raw     (sw_raw),
        .pb_raw     (pb_raw),
        .sw_db      (sw_db),
        .pb_db      (pb_db),
        .pb_rise    (pb_rise),
        .pb_fall    (pb_fall),
        .sw_change  (sw_change),
        .led_wdata  (led_wdata),
        .led_we     (led_we),
        .led_mode   (led_mode),
        .led_duty   (led_duty),
        .LED        (LED)
    );

    always #5 clk = ~clk;

    // Model state: edges since reset, accepted levels, start edge of each
    // mismatch run, raw history for the synchroniser delay, LED register.
    int                 m_n;
    logic [NUM_IN-1:0]  m_level;
    logic [NUM_IN-1:0]  m_rise;
    logic [NUM_IN-1:0]  m_fall;
    int                 m_run_start [NUM_IN];
    logic [NUM_IN-1:0]  m_hist [$];
    logic [NUM_LED-1:0] m_led_reg;
    logic [NUM_LED-1:0] m_led;

    // Ticks fall on edges n with n % TICK_DIV == TICK_DIV-1.
    function automatic int ticks_in(input int a, input int e);
        return (e + 1) / TICK_DIV - a / TICK_DIV;
    endfunction

    task automatic model_edge();
        logic [NUM_IN-1:0] s_vec;
        bit                phase;
        bit                pwm_on;
        if (!rst_n) begin
            m_n       = 0;
            m_level   = '0;
            m_rise    = '0;
            m_fall    = '0;
            m_hist    = {};
            m_led_reg = '0;
            m_led     = '0;
            for (int i = 0; i < NUM_IN; i++) m_run_start[i] = -1;
            return;
        end
        s_vec = (m_hist.size() == SYNC_STAGES) ? m_hist[0] : '0;
        if (m_hist.size() == SYNC_STAGES) void'(m_hist.pop_front());
        m_hist.push_back({pb_raw, sw_raw});
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (s_vec[i] == m_level[i]) begin
                m_run_start[i] = -1;
            end else begin
                if (m_run_start[i] < 0) m_run_start[i] = m_n;
                if ((m_n % TICK_DIV == TICK_DIV - 1) &&
                    (ticks_in(m_run_start[i], m_n) == STABLE_TICKS)) begin
                    m_level[i]     = s_vec[i];
                    m_rise[i]      = s_vec[i];
                    m_fall[i]      = !s_vec[i];
                    m_run_start[i] = -1;
                end
            end
        end
        phase  = (((m_n / TICK_DIV) / BLINK_TICKS) % 2) == 1;
        pwm_on = (m_n % (1 << PWM_BITS)) < int'(led_duty);
        case (led_mode)
            2'd1:    m_led = phase  ? m_led_reg : '0;
            2'd2:    m_led = pwm_on ? m_led_reg : '0;
            default: m_led = m_led_reg;
        endcase
        if (led_we) m_led_reg = led_wdata;
        m_n++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("sw_db",     32'(sw_db),     32'(m_level[NUM_SW-1:0]));
        chk("pb_db",     32'(pb_db),     32'(m_level[NUM_IN-1:NUM_SW]));
        chk("pb_rise",   32'(pb_rise),   32'(m_rise[NUM_IN-1:NUM_SW]));
        chk("pb_fall",   32'(pb_fall),   32'(m_fall[NUM_IN-1:NUM_SW]));
        chk("sw_change", 32'(sw_change), 32'(|(m_rise[NUM_SW-1:0] | m_fall[NUM_SW-1:0])));
        chk("LED",       32'(LED),       32'(m_led));
    endtask

    initial begin
        int cnt;
        int other;
        int first;

        // Reset state
        repeat (3) cycle();
        chk("reset_all_zero", 32'({sw_db, pb_db, pb_rise, pb_fall, sw_change, LED}), 32'd0);
        rst_n = 1'b1;
        repeat (5) cycle();

        // Single button press: latency window and exactly one rise
        pb_raw[2] = 1'b1;
        cnt = 0; other = 0; first = -1;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            if (pb_rise[2]) cnt++;
            if ((pb_rise & 5'b11011) != 0 || pb_fall != 0 || sw_change) other++;
            if (pb_db[2] && first < 0) first = k;
        end
        chk("pb2_latency_in_window", 32'(first >= 11 && first <= 14), 32'd1);
        chk("pb2_rise_count", 32'(cnt), 32'd1);
        chk("pb2_other_pulses", 32'(other), 32'd0);

        // Bouncing button: no pulses until it settles
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) pb_raw[0] = ~pb_raw[0];
            cycle();
            if (pb_rise[0] || pb_fall[0]) cnt++;
        end
        chk("bounce_no_pulse", 32'(cnt), 32'd0);
        pb_raw[0] = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (pb_rise[0]) cnt++;
        end
        chk("settle_one_rise", 32'(cnt), 32'd1);
        chk("settle_pb0_level", 32'(pb_db[0]), 32'd1);

        // Switches
        sw_raw = 16'h8001;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (sw_change) cnt++;
        end
        chk("sw_db_8001", 32'(sw_db), 32'h8001);
        chk("sw_change_count_1", 32'(cnt), 32'd1);
        sw_raw = 16'h0001;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (sw_change) cnt++;
        end
        chk("sw_db_0001", 32'(sw_db), 32'h0001);
        chk("sw_change_count_2", 32'(cnt), 32'd1);

        // LED direct and blink
        led_wdata = 16'hA5A5;
        led_we    = 1'b1;
        led_mode  = 2'd0;
        cycle();
        led_we = 1'b0;
        cycle();
        chk("led_direct", 32'(LED), 32'hA5A5);
        led_mode = 2'd1;
        cycle();
        cnt = 0;
        for (int k = 0; k < 32; k++) begin
            cycle();
            if (LED == 16'hA5A5) cnt++;
        end
        chk("led_blink_on_cycles", 32'(cnt), 32'd16);

        // PWM dimming at several duties
        led_mode = 2'd2;
        for (int d = 0; d < 3; d++) begin
            led_duty = (d == 0) ? 4'd4 : (d == 1) ? 4'd0 : 4'd15;
            cycle();
            cnt = 0;
            for (int k = 0; k < 16; k++) begin
                cycle();
                if (LED == 16'hA5A5) cnt++;
            end
            chk("led_pwm_on_cycles", 32'(cnt), 32'(int'(led_duty)));
        end

        // Reset in the middle of a debounce run
        pb_raw[1] = 1'b1;
        repeat (10) cycle();
        chk("mid_debounce_not_yet", 32'(pb_db[1]), 32'd0);
        rst_n = 1'b0;
        repeat (2) cycle();
        chk("mid_reset_outputs_zero", 32'({sw_db, pb_db, pb_rise, pb_fall, sw_change, LED}), 32'd0);
        rst_n = 1'b1;
        first = -1;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            if (pb_db[1] && first < 0) first = k;
        end
        chk("post_reset_full_debounce", 32'(first >= 11 && first <= 14), 32'd1);

        // Random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(15) == 0) begin
                int b;
                b = $urandom_range(NUM_IN - 1);
                if (b < NUM_SW) sw_raw[b] = ~sw_raw[b];
                else pb_raw[b - NUM_SW] = ~pb_raw[b - NUM_SW];
            end
            led_we    = ($urandom_range(7) == 0);
            led_wdata = NUM_LED'($urandom);
            if ($urandom_range(31) == 0) led_mode = 2'($urandom);
            if ($urandom_range(31) == 0) led_duty = PWM_BITS'($urandom);
            rst_n = ($urandom_range(299) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
